// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU sequencer
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_PASSA = 4'h0;
    localparam alu_op_t OP_ADD   = 4'h1;
    localparam alu_op_t OP_SUB   = 4'h2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_HOLD
    } seq_state_t;

    // Command FIFO payload: op, operand, writeback flag (13 bits)
    typedef struct packed {
        alu_op_t    op;
        logic [7:0] data;
        logic       wb;
    } cmd_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - command, ALU and result signal bundle for alu_seq
interface alu_seq_if;
    import alu_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    alu_op_t    cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_wb;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    alu_op_t    alu_op;
    logic [7:0] alu_res;
    logic       alu_z;
    logic       alu_c;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic       res_carry;

    logic [7:0] acc;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, cmd_wb,
        input  alu_res, alu_z, alu_c, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output res_valid, res_data, res_zero, res_carry, acc, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, cmd_wb,
        output alu_res, alu_z, alu_c, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  res_valid, res_data, res_zero, res_carry, acc, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - power-of-two command FIFO with combinational head read
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - accumulator sequencer issuing buffered commands to a combinational ALU
module alu_seq
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.master bus
);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    seq_state_t state_q;
    logic [3:0] cnt_q;
    logic [7:0] acc_q, alu_b_q, res_data_q;
    alu_op_t    alu_op_q;
    logic       wb_q, res_valid_q, res_zero_q, res_carry_q;

    cmd_t push_cmd, head;
    logic full, empty, pop, sample;

    assign push_cmd = {bus.cmd_op, bus.cmd_data, bus.cmd_wb};

    alu_cmd_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(cmd_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (bus.cmd_valid),
        .push_data_i(push_cmd),
        .pop_i      (pop),
        .pop_data_o (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    // HOLD can hand off straight to the next command in the handshake cycle.
    assign pop = !empty && ((state_q == S_IDLE) ||
                            (state_q == S_HOLD && res_valid_q && bus.res_ready));

    assign sample = (state_q == S_ISSUE && SETTLE == 1) ||
                    (state_q == S_SETTLE && cnt_q == 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_PASSA;
            wb_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
        end else begin
            if (pop) begin
                alu_b_q  <= head.data;
                alu_op_q <= head.op;
                wb_q     <= head.wb;
            end
            if (sample) begin
                res_data_q  <= bus.alu_res;
                res_zero_q  <= bus.alu_z;
                res_carry_q <= bus.alu_c;
                res_valid_q <= 1'b1;
                if (wb_q) acc_q <= bus.alu_res;
            end
            case (state_q)
                S_IDLE: begin
                    if (!empty) state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt_q   <= SETTLE_M1;
                    state_q <= (SETTLE == 1) ? S_HOLD : S_SETTLE;
                end
                S_SETTLE: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == 4'd1) state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= empty ? S_IDLE : S_ISSUE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.alu_a     = acc_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_carry = res_carry_q;
    assign bus.acc       = acc_q;
    assign bus.busy      = (state_q != S_IDLE) || !empty;

endmodule
